logic_array_pipelined: RTL and testbench
========================================

LOGIC_ARRAY_PIPELINED -- requirements
Module: logic_array_pipelined

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits, legal range 1..64.
REQ-002 Parameter CNT_W, default 16: width of the completed-operation counter.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous assertion, active-low.
REQ-005 Port in_valid, input, 1: a, b and op are valid this cycle.
REQ-006 Port in_ready, output, 1: the block accepts the input this cycle.
REQ-007 Port a, input, WIDTH: first operand.
REQ-008 Port b, input, WIDTH: second operand.
REQ-009 Port op, input, 3: operation select.
REQ-010 Port out_valid, output, 1: out, out_zero and out_ones are valid.
REQ-011 Port out_ready, input, 1: the consumer accepts the output this cycle.
REQ-012 Port out, output, WIDTH: bitwise result.
REQ-013 Port out_zero, output, 1: the result equals all zeros.
REQ-014 Port out_ones, output, 1: the result equals all ones.
REQ-015 Port op_count, output, CNT_W: number of output handshakes completed.

Function
REQ-016 Operation codes SHALL be: 000 NOR, 001 OR, 010 AND, 011 NAND, 100 XOR, 101 XNOR, 110 NOT a (b ignored), 111 pass a; all are applied per bit i across WIDTH.
REQ-017 An input handshake SHALL occur when in_valid and in_ready are both 1 in the same cycle; an output handshake SHALL occur when out_valid and out_ready are both 1.
REQ-018 The pipeline SHALL have two register stages: S1 captures a, b and op; S2 captures the computed result and the zero/ones flags.
REQ-019 Latency with no stall SHALL be 2 cycles: an input handshake at edge N produces out_valid=1 after edge N+2.
REQ-020 S2 SHALL load when S2 is empty or an output handshake occurs in the same cycle.
REQ-021 S1 SHALL advance to S2 whenever S2 loads.
REQ-022 in_ready SHALL be 1 when S1 is empty or S1 advances in that cycle.
REQ-023 Throughput SHALL be one operation per cycle when out_ready is held at 1.
REQ-024 When out_ready=0 and both stages are full, in_ready SHALL be 0 and out, out_zero, out_ones and op SHALL hold their values.
REQ-025 The pipeline SHALL neither drop nor duplicate a transaction under any pattern of in_valid and out_ready; results SHALL leave in input order.
REQ-026 out_valid SHALL stay 1, and out SHALL stay stable, from the cycle out_valid rises until the output handshake.
REQ-027 op_count SHALL increment by 1 on each output handshake and wrap from 2^CNT_W-1 to 0.
REQ-028 Input and output handshakes in the same cycle SHALL both take effect.
REQ-029 out_zero and out_ones SHALL be computed from the same result that is registered into out.

Reset
REQ-030 Asserting rst_n=0 SHALL, without waiting for a clock edge, clear both stage-valid bits, out_valid, out, out_zero and op_count to 0.
REQ-031 During reset out_ones SHALL be 0 and in_ready SHALL be 0.
REQ-032 Reset SHALL deassert synchronously to clk through a two-flop synchronizer inside the block; in_ready SHALL rise on the first edge after the synchronized release.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight transactions; no output handshake SHALL follow for them.

Structure
REQ-034 A shared package logic_array_pkg SHALL hold the op-code constants (OP_NOR..OP_PASS) and the 3-bit op type.
REQ-035 Sub-module logic_array_alu (combinational, parameter WIDTH) SHALL compute the result, zero flag and ones flag from a, b and op; it is instantiated once, between S1 and S2.

Verification
REQ-036 WIDTH=16, out_ready=1, a=16'hF0F0, b=16'h0FF0, op=000 -> out=16'h000F after 2 cycles, out_zero=0, out_ones=0.
REQ-037 Stream all 8 ops back-to-back with a=16'hAAAA, b=16'h5555 -> outputs 0000, FFFF, 0000, FFFF, FFFF, 0000, 5555, AAAA in order, one per cycle; out_ones=1 for OR, NAND and XOR.
REQ-038 Stall: out_ready=0 while 3 inputs are offered -> 2 accepted, in_ready=0, out frozen; release out_ready -> 3 results emitted in order with no loss.
REQ-039 CNT_W=4: 17 output handshakes -> op_count=1 (wrap verified).
REQ-040 rst_n pulsed low with both stages full -> out_valid=0 immediately, op_count=0, in_ready=0 until the synchronized release, and no stale output afterwards.
REQ-041 WIDTH=1 and WIDTH=64 builds: run a random compare against a bitwise model for 10000 transactions with random out_ready -> zero mismatches.

Source files
------------

// File: rtl/logic_array_pkg.sv
// Shared op-code definitions for the pipelined bitwise logic array.
package logic_array_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_NOR  = 3'b000;
    localparam op_t OP_OR   = 3'b001;
    localparam op_t OP_AND  = 3'b010;
    localparam op_t OP_NAND = 3'b011;
    localparam op_t OP_XOR  = 3'b100;
    localparam op_t OP_XNOR = 3'b101;
    localparam op_t OP_NOTA = 3'b110;
    localparam op_t OP_PASS = 3'b111;

endpackage

// File: rtl/logic_array_alu.sv
// Combinational bitwise operator with all-zeros / all-ones detection.
module logic_array_alu
    import logic_array_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  op_t              op_i,
    output logic [WIDTH-1:0] res_o,
    output logic             zero_o,
    output logic             ones_o
);

    always_comb begin
        res_o = '0;
        case (op_i)
            OP_NOR:  res_o = ~(a_i | b_i);
            OP_OR:   res_o = a_i | b_i;
            OP_AND:  res_o = a_i & b_i;
            OP_NAND: res_o = ~(a_i & b_i);
            OP_XOR:  res_o = a_i ^ b_i;
            OP_XNOR: res_o = ~(a_i ^ b_i);
            OP_NOTA: res_o = ~a_i;
            default: res_o = a_i;
        endcase
    end

    // Flags derive from the same res_o that the top registers into out.
    assign zero_o = ~|res_o;
    assign ones_o = &res_o;

endmodule

// File: rtl/logic_array_pipelined.sv
// Two-stage valid/ready pipeline around logic_array_alu with a handshake counter.
module logic_array_pipelined
    import logic_array_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_zero,
    output logic             out_ones,
    output logic [CNT_W-1:0] op_count
);

    // Assert asynchronously, release two edges after rst_n rises.
    logic rst_meta_q, rst_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    logic             rdy_en_q;
    logic [2:1]       vld_q, vld_d;
    logic [WIDTH-1:0] a_q, b_q, a_d, b_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d, ones_q, ones_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] alu_res;
    logic             alu_zero, alu_ones;
    logic             s2_load, in_hs, out_hs;

    logic_array_alu #(.WIDTH(WIDTH)) u_alu (
        .a_i    (a_q),
        .b_i    (b_q),
        .op_i   (op_q),
        .res_o  (alu_res),
        .zero_o (alu_zero),
        .ones_o (alu_ones)
    );

    assign out_hs    = vld_q[2] & out_ready;
    assign s2_load   = ~vld_q[2] | out_hs;
    assign in_ready  = rdy_en_q & (~vld_q[1] | s2_load);
    assign in_hs     = in_valid & in_ready;

    always_comb begin
        vld_d  = vld_q;
        a_d    = a_q;
        b_d    = b_q;
        op_d   = op_q;
        res_d  = res_q;
        zero_d = zero_q;
        ones_d = ones_q;
        cnt_d  = cnt_q;
        if (in_ready) vld_d[1] = in_valid;
        if (in_hs) begin
            a_d  = a;
            b_d  = b;
            op_d = op;
        end
        if (s2_load) vld_d[2] = vld_q[1];
        // Result registers only move when a real transaction arrives, so a
        // drained S2 keeps showing the last value rather than junk.
        if (s2_load && vld_q[1]) begin
            res_d  = alu_res;
            zero_d = alu_zero;
            ones_d = alu_ones;
        end
        if (out_hs) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            rdy_en_q <= 1'b0;
            vld_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_NOR;
            res_q    <= '0;
            zero_q   <= 1'b0;
            ones_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            vld_q    <= vld_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            ones_q   <= ones_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid = vld_q[2];
    assign out       = res_q;
    assign out_zero  = zero_q;
    assign out_ones  = ones_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_logic_array_pipelined.sv
// Bench: three builds (16/CNT_W=4, 1, 64 bits) share one stimulus stream, each with its own scoreboard.
module tb_logic_array_pipelined;

    typedef struct packed {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
    } txn_t;

    logic        clk, rst_n, in_valid, out_ready;
    logic [63:0] a, b;
    logic [2:0]  op;

    logic        ir16, ov16, z16, o16;
    logic [15:0] out16;
    logic [3:0]  cnt16;
    logic        ir1, ov1, z1, o1;
    logic [0:0]  out1;
    logic [15:0] cnt1;
    logic        ir64, ov64, z64, o64;
    logic [63:0] out64;
    logic [15:0] cnt64;

    logic_array_pipelined #(.WIDTH(16), .CNT_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16),
        .a(a[15:0]), .b(b[15:0]), .op(op), .out_valid(ov16), .out_ready(out_ready),
        .out(out16), .out_zero(z16), .out_ones(o16), .op_count(cnt16));

    logic_array_pipelined #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
        .a(a[0:0]), .b(b[0:0]), .op(op), .out_valid(ov1), .out_ready(out_ready),
        .out(out1), .out_zero(z1), .out_ones(o1), .op_count(cnt1));

    logic_array_pipelined #(.WIDTH(64)) u_w64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir64),
        .a(a), .b(b), .op(op), .out_valid(ov64), .out_ready(out_ready),
        .out(out64), .out_zero(z64), .out_ones(o64), .op_count(cnt64));

    logic [63:0] d_out [3];
    logic        d_ir [3], d_ov [3], d_z [3], d_o [3];
    logic [15:0] d_cnt [3];

    assign d_out[0] = 64'(out16);
    assign d_out[1] = 64'(out1);
    assign d_out[2] = out64;
    assign d_ir  = '{ir16, ir1, ir64};
    assign d_ov  = '{ov16, ov1, ov64};
    assign d_z   = '{z16, z1, z64};
    assign d_o   = '{o16, o1, o64};
    assign d_cnt[0] = 16'(cnt16);
    assign d_cnt[1] = cnt1;
    assign d_cnt[2] = cnt64;

    localparam int W  [3] = '{16, 1, 64};
    localparam int CW [3] = '{4, 16, 16};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   passed = 0, total = 0;
    txn_t sbq [3][$];
    int   hs_cnt [3];
    int   cyc = 0;
    logic [3:0] tt [8];

    logic        smp_ir, smp_ov, smp_acc, smp_z, smp_o;
    logic [15:0] smp_out;
    logic [15:0] smp_cnt16, smp_cnt64;
    logic [15:0] olog [$];
    logic        onelog [$];
    int          hcyc [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Truth-table model: bit i of the result is tt[op] indexed by {a[i], b[i]}.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [63:0] x,
                                          input logic [63:0] y, input int w);
        logic [63:0] r;
        logic [3:0]  t;
        r = '0;
        t = tt[o];
        for (int i = 0; i < w; i++) r[i] = t[{x[i], y[i]}];
        return r;
    endfunction

    function automatic logic [63:0] wmask(input int w);
        return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            sbq[k].delete();
            hs_cnt[k] = 0;
        end
    endtask

    task automatic cycle(input logic iv, input logic orr, input logic [2:0] o,
                         input logic [63:0] x, input logic [63:0] y);
        txn_t        e;
        logic [63:0] exp;
        @(negedge clk);
        in_valid = iv; out_ready = orr; op = o; a = x; b = y;
        #1;
        cyc++;
        smp_ir = ir16; smp_ov = ov16; smp_out = out16; smp_z = z16; smp_o = o16;
        smp_cnt16 = 16'(cnt16); smp_cnt64 = cnt64;
        smp_acc = iv && ir16;
        for (int k = 0; k < 3; k++) begin
            if (d_ov[k] && orr) begin
                if (sbq[k].size() == 0) begin
                    chk($sformatf("spurious_out_w%0d", W[k]), 64'd1, 64'd0);
                end else begin
                    e   = sbq[k].pop_front();
                    exp = model(e.op, e.a, e.b, W[k]);
                    chk($sformatf("out_w%0d", W[k]), d_out[k], exp);
                    chk($sformatf("zero_w%0d", W[k]), 64'(d_z[k]), 64'(exp == 64'd0));
                    chk($sformatf("ones_w%0d", W[k]), 64'(d_o[k]), 64'(exp == wmask(W[k])));
                    chk($sformatf("cnt_w%0d", W[k]), 64'(d_cnt[k]),
                        64'(hs_cnt[k] % (1 << CW[k])));
                    hs_cnt[k]++;
                    if (k == 0) begin
                        olog.push_back(out16);
                        onelog.push_back(o16);
                        hcyc.push_back(cyc);
                    end
                end
            end
            if (iv && d_ir[k]) sbq[k].push_back('{o, x, y});
        end
        @(posedge clk);
    endtask

    task automatic idle(input logic orr);
        cycle(1'b0, orr, 3'd0, 64'd0, 64'd0);
    endtask

    task automatic offer(input logic orr, input logic [2:0] o, input logic [63:0] x,
                         input logic [63:0] y);
        int n;
        n = 0;
        do begin
            cycle(1'b1, orr, o, x, y);
            n++;
        end while (!smp_acc && n < 50);
        if (!smp_acc) chk("offer_timeout", 64'd0, 64'd1);
    endtask

    task automatic release_reset();
        int n;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b0);
        chk("ir_low_during_sync", 64'(smp_ir), 64'd0);
        n = 0;
        while (!smp_ir && n < 6) begin
            idle(1'b0);
            n++;
        end
        chk("ir_after_sync_release", 64'(smp_ir), 64'd1);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_ov"},   64'(ov16), 64'd0);
        chk({tag, "_out"},  64'(out16), 64'd0);
        chk({tag, "_zero"}, 64'(z16), 64'd0);
        chk({tag, "_ones"}, 64'(o16), 64'd0);
        chk({tag, "_ir"},   64'(ir16), 64'd0);
        chk({tag, "_cnt"},  64'(cnt16), 64'd0);
        chk({tag, "_ov64"}, 64'(ov64), 64'd0);
    endtask

    initial begin
        logic [15:0] exp37 [8];
        logic [63:0] xs [3];
        logic [2:0]  os [3];
        logic [15:0] frz;
        logic        iv, orr, hold;
        logic [2:0]  ro;
        logic [63:0] ra, rb;
        int          acc, ncyc;

        tt[0] = 4'b0001; tt[1] = 4'b1110; tt[2] = 4'b1000; tt[3] = 4'b0111;
        tt[4] = 4'b0110; tt[5] = 4'b1001; tt[6] = 4'b0011; tt[7] = 4'b1100;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0;
        model_reset();
        #2;
        reset_checks("por");
        repeat (2) @(negedge clk);
        release_reset();

        // Single NOR, two-cycle latency.
        cycle(1'b1, 1'b1, 3'b000, 64'hF0F0, 64'h0FF0);
        chk("lat_accept", 64'(smp_acc), 64'd1);
        idle(1'b1);
        chk("lat_ov_cycle1", 64'(smp_ov), 64'd0);
        idle(1'b1);
        chk("lat_ov_cycle2", 64'(smp_ov), 64'd1);
        chk("nor_out", 64'(smp_out), 64'h000F);
        chk("nor_zero", 64'(smp_z), 64'd0);
        chk("nor_ones", 64'(smp_o), 64'd0);

        // All eight ops back-to-back.
        exp37 = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF,
                  16'hFFFF, 16'h0000, 16'h5555, 16'hAAAA};
        olog.delete(); onelog.delete(); hcyc.delete();
        for (int i = 0; i < 8; i++)
            offer(1'b1, 3'(i), {$urandom, 16'h0, 16'hAAAA}, {$urandom, 16'h0, 16'h5555});
        repeat (4) idle(1'b1);
        chk("stream_count", 64'(olog.size()), 64'd8);
        if (olog.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("stream_out%0d", i), 64'(olog[i]), 64'(exp37[i]));
                chk($sformatf("stream_ones%0d", i), 64'(onelog[i]),
                    64'(i == 1 || i == 3 || i == 4));
            end
            chk("stream_b2b", 64'(hcyc[7] - hcyc[0]), 64'd7);
        end

        // Stall with out_ready low: third input must be refused and out frozen.
        os = '{3'b100, 3'b010, 3'b101};
        for (int i = 0; i < 3; i++) xs[i] = {$urandom, $urandom};
        olog.delete();
        cycle(1'b1, 1'b0, os[0], xs[0], ~xs[0]);
        chk("stall_acc0", 64'(smp_acc), 64'd1);
        cycle(1'b1, 1'b0, os[1], xs[1], ~xs[0]);
        chk("stall_acc1", 64'(smp_acc), 64'd1);
        cycle(1'b1, 1'b0, os[2], xs[2], xs[1]);
        chk("stall_ir", 64'(smp_ir), 64'd0);
        chk("stall_ov", 64'(smp_ov), 64'd1);
        frz = smp_out;
        cycle(1'b1, 1'b0, os[2], xs[2], xs[1]);
        chk("stall_ir_hold", 64'(smp_ir), 64'd0);
        chk("stall_frozen", 64'(smp_out), 64'(frz));
        chk("stall_frozen_val", 64'(frz), model(os[0], xs[0], ~xs[0], 16));
        offer(1'b1, os[2], xs[2], xs[1]);
        repeat (4) idle(1'b1);
        chk("stall_count", 64'(olog.size()), 64'd3);
        if (olog.size() == 3) begin
            chk("stall_r0", 64'(olog[0]), model(os[0], xs[0], ~xs[0], 16));
            chk("stall_r1", 64'(olog[1]), model(os[1], xs[1], ~xs[0], 16));
            chk("stall_r2", 64'(olog[2]), model(os[2], xs[2], xs[1], 16));
        end

        // Reset with both stages full.
        offer(1'b0, 3'b001, 64'h1234, 64'h4321);
        offer(1'b0, 3'b011, 64'h00FF, 64'h0F0F);
        idle(1'b0);
        chk("pre_rst_ov", 64'(smp_ov), 64'd1);
        chk("pre_rst_ir", 64'(smp_ir), 64'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        reset_checks("mid");
        model_reset();
        release_reset();
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            chk("no_stale_ov", 64'(smp_ov), 64'd0);
        end

        // Counter wrap on the CNT_W=4 build.
        for (int i = 0; i < 17; i++) offer(1'b1, 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
        repeat (4) idle(1'b1);
        chk("wrap_cnt4", 64'(smp_cnt16), 64'd1);
        chk("cnt16_17", 64'(smp_cnt64), 64'd17);

        // Random traffic on all three builds.
        acc = 0; ncyc = 0; hold = 1'b0;
        ro = '0; ra = '0; rb = '0;
        while (acc < 10000 && ncyc < 40000) begin
            iv  = ($urandom % 4) != 0;
            orr = ($urandom % 4) != 0;
            if (!hold) begin
                ro = 3'($urandom);
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
            end
            cycle(iv, orr, ro, ra, rb);
            if (smp_acc) acc++;
            hold = iv && !smp_acc;
            ncyc++;
        end
        chk("rand_budget", 64'(acc), 64'd10000);
        repeat (6) idle(1'b1);
        for (int k = 0; k < 3; k++)
            chk($sformatf("drained_w%0d", W[k]), 64'(sbq[k].size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
